// File: rtl/mem_dump_pkg.sv
// mem_dump_pkg: shared FSM state type and ASCII constants for the memory hex dumper.
package mem_dump_pkg;
  typedef enum logic [2:0] {IDLE, READ, WAIT, EMIT, NL, DONE} state_t;
  localparam logic [7:0] ASCII_NL   = 8'h0A;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_A_LC = 8'h61;
endpackage

// File: rtl/hex_nibble_to_ascii.sv
// hex_nibble_to_ascii: maps one 4-bit value to its lowercase ASCII hex digit.
module hex_nibble_to_ascii
  import mem_dump_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_ascii
);
  assign o_ascii = (i_nibble < 4'd10) ? ASCII_0 + {4'h0, i_nibble}
                                      : ASCII_A_LC + {4'h0, i_nibble} - 8'd10;
endmodule

// File: rtl/mem_dump.sv
// mem_dump: reads a word range from a 1-cycle synchronous memory and streams it as reloadable ASCII hex text, one word per line.
module mem_dump
  import mem_dump_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready
);
  localparam int NIB   = DATA_W / 4;
  localparam int NIB_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_remain;
  logic [DATA_W-1:0]   r_shift;
  logic [NIB_W-1:0]    r_nib;
  logic [7:0]          w_ascii;
  logic                w_hs;
  logic                w_last_nib;

  assign w_hs       = out_valid && out_ready;
  assign w_last_nib = r_nib == NIB_W'(NIB - 1);

  hex_nibble_to_ascii u_hex (
    .i_nibble (r_shift[DATA_W-1 -: 4]),
    .o_ascii  (w_ascii)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (word_count == '0) ? DONE : READ;
      READ:    w_next = WAIT;
      WAIT:    w_next = EMIT;
      EMIT:    if (out_ready && w_last_nib) w_next = NL;
      NL:      if (out_ready) w_next = (r_remain == (ADDR_W+1)'(1)) ? DONE : READ;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = r_state inside {READ, WAIT, EMIT, NL};
    done      = r_state == DONE;
    mem_rd_en = r_state == READ;
    mem_addr  = r_addr;
    out_valid = r_state inside {EMIT, NL};
    out_data  = (r_state == EMIT) ? w_ascii : (r_state == NL) ? ASCII_NL : 8'h00;
  end

  // Shifting left keeps the next digit to send in the top nibble.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_addr   <= '0;
      r_remain <= '0;
      r_shift  <= '0;
      r_nib    <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_addr   <= base_addr;
        r_remain <= word_count;
      end
      if (r_state == WAIT) begin
        r_shift <= mem_rdata;
        r_nib   <= '0;
      end
      if (r_state == EMIT && w_hs) begin
        r_shift <= r_shift << 4;
        r_nib   <= r_nib + NIB_W'(1);
      end
      if (r_state == NL && w_hs) begin
        r_addr   <= r_addr + ADDR_W'(1);
        r_remain <= r_remain - (ADDR_W+1)'(1);
      end
    end
endmodule

// File: tb/tb_mem_dump.sv
// tb_mem_dump: directed tests for mem_dump against a string-level model of the dump text.
module tb_mem_dump;
  logic        clk = 0;
  logic        rst_n;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] word_count;
  logic        busy, done, mem_rd_en, out_valid, out_ready;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic [7:0]  out_data;

  logic [31:0] mem [0:1023];
  logic [7:0]  exp_q[$];
  int          addr_q[$];
  string       got;
  int          n_pass = 0, n_total = 0, done_cnt = 0;
  bit          rand_mode = 0;
  bit          stall = 0;
  logic [7:0]  stall_data;

  mem_dump dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_s(string name, string act, string exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst_n) stall = 0;
    else begin
      if (stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, stall_data);
      end
      if (mem_rd_en) begin
        chk("read_expected", addr_q.size() > 0, 1);
        if (addr_q.size() > 0) chk("mem_addr", mem_addr, addr_q.pop_front());
      end
      if (out_valid && out_ready) begin
        chk("char_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("out_data", out_data, exp_q.pop_front());
        got = {got, $sformatf("%c", out_data)};
      end
      if (done) done_cnt++;
      stall = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  initial forever begin
    @(posedge clk);
    #2 out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Model: each word becomes its 8-digit lowercase hex text plus newline.
  task automatic launch(int base, int cnt);
    for (int k = 0; k < cnt; k++) begin
      int a = (base + k) % 1024;
      string s = $sformatf("%08h\n", mem[a]);
      addr_q.push_back(a);
      for (int j = 0; j < s.len(); j++) exp_q.push_back(s[j]);
    end
    got = "";
    @(posedge clk);
    #1 start = 1; base_addr = 10'(base); word_count = 11'(cnt);
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic wait_done(int d0);
    for (int i = 0; i < 20000 && done_cnt == d0; i++) @(posedge clk);
    chk("done_seen", done_cnt, d0 + 1);
    chk("all_chars_sent", exp_q.size(), 0);
    chk("all_reads_made", addr_q.size(), 0);
  endtask

  initial begin
    string exp1 = "00a00093\n";
    int d0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h9E3779B9 * i + 32'h0F1E2D3C;
    mem[0] = 32'h00A00093;
    rst_n = 0; start = 0; base_addr = 0; word_count = 0; out_ready = 1;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    rst_n = 1;

    d0 = done_cnt;
    launch(0, 1);
    for (int c = 1; c <= 12; c++) begin
      chk($sformatf("t1_rd_en_c%0d", c), mem_rd_en, c == 1);
      chk($sformatf("t1_busy_c%0d", c), busy, c <= 11);
      chk($sformatf("t1_done_c%0d", c), done, c == 12);
      chk($sformatf("t1_valid_c%0d", c), out_valid, c >= 3 && c <= 11);
      if (c >= 3 && c <= 11) chk($sformatf("t1_char_c%0d", c), out_data, exp1[c-3]);
      @(posedge clk); #1;
    end
    wait_done(d0);
    chk_s("t1_text", got, "00a00093\n");

    rand_mode = 1;
    d0 = done_cnt;
    launch(0, 1);
    wait_done(d0);
    chk_s("bp_text", got, "00a00093\n");
    d0 = done_cnt;
    launch(3, 3);
    wait_done(d0);
    rand_mode = 0;

    mem[10'h3FF] = 32'hDEADBEEF;
    mem[0] = 32'h00000013;
    d0 = done_cnt;
    launch(10'h3FF, 2);
    wait_done(d0);
    chk_s("wrap_text", got, "deadbeef\n00000013\n");

    d0 = done_cnt;
    launch(7, 0);
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    chk("z_rd_en", mem_rd_en, 0);
    chk("z_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("z_done_off", done, 0);
    chk("z_busy_off", busy, 0);
    repeat (3) @(posedge clk);
    chk("z_done_cnt", done_cnt, d0 + 1);

    d0 = done_cnt;
    launch(4, 4);
    repeat (15) @(posedge clk);
    chk("mid_emit_valid", out_valid, 1);
    #3 rst_n = 0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_rd_en", mem_rd_en, 0);
    chk("mr_addr", mem_addr, 0);
    chk("mr_valid", out_valid, 0);
    chk("mr_data", out_data, 0);
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    repeat (3) @(posedge clk);
    chk("mr_no_done", done_cnt, d0);
    d0 = done_cnt;
    launch(4, 4);
    wait_done(d0);
    chk("mr_len", got.len(), 36);

    d0 = done_cnt;
    launch(20, 2);
    repeat (10) @(posedge clk);
    #1;
    chk("sb_nl_char", out_data, 8'h0A);
    start = 1; base_addr = 10'd99; word_count = 11'd5;
    @(posedge clk);
    #1 start = 0;
    wait_done(d0);
    repeat (4) @(posedge clk);
    chk("sb_one_done", done_cnt, d0 + 1);
    chk("sb_len", got.len(), 18);

    d0 = done_cnt;
    launch(5, 1024);
    wait_done(d0);
    chk("full_len", got.len(), 1024 * 9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
